dmem_access_unit: RTL and testbench



---
 rtl/dmem_access_unit.sv | 217 +++++++++++++++++++++
 tb/tb_dmem_access_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// dmem_access_unit
// Multi-cycle data-memory responder for the RV32I core. Accepts one load or
// store at a time, runs it against a word-wide synchronous-read array (doing
// read-modify-write for byte/half stores) and returns extended load data on a
// valid/ready response channel.
//
// Build option:
//   DMEM_MISALIGN_TRAP_EN  - when defined, misaligned half/word accesses are
//                            not executed and answer with rsp_err_o=1.
//                            When undefined, such accesses are silently
//                            aligned and rsp_err_o is tied low.

module dmem_access_unit #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_ext_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    state_e              state;
    logic                we_q;
    size_e               size_q;
    logic                sign_q;
    logic [1:0]          lane_q;
    logic [IDX_W-1:0]    idx_q;
    logic [31:0]         wdata_q;
    logic                err_q;
    logic                rsp_err_q;
    logic [31:0]         rd_word_q;

    logic [31:0]         mem [DEPTH_WORDS];

    size_e               req_size;
    logic                req_sign;
    logic                req_trap;
    logic [31:0]         load_data;
    logic [31:0]         wr_data;
    logic                mem_we;

    // Address bits above the array index are deliberately dropped (wrap).
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr_i[31:IDX_W+2];

    // Decode the requested access size and signedness from the ext code.
    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path through the case leaves it unassigned and infers a latch.
        req_size = SZ_WORD;
        req_sign = 1'b0;
        if (req_we_i) begin
            case (req_ext_i)
                3'b000:  req_size = SZ_BYTE;
                3'b001:  req_size = SZ_HALF;
                default: req_size = SZ_WORD;
            endcase
        end else begin
            case (req_ext_i)
                3'b000: begin req_size = SZ_BYTE; req_sign = 1'b1; end
                3'b001: begin req_size = SZ_HALF; req_sign = 1'b1; end
                3'b010: req_size = SZ_BYTE;
                3'b011: req_size = SZ_HALF;
                default: req_size = SZ_WORD;
            endcase
        end
    end

    // Flag accesses that must be refused instead of executed.
`ifdef DMEM_MISALIGN_TRAP_EN
    assign req_trap = ((req_size == SZ_HALF) && req_addr_i[0]) ||
                      ((req_size == SZ_WORD) && (req_addr_i[1:0] != 2'b00));
    assign rsp_err_o = rsp_err_q;
`else
    assign req_trap  = 1'b0;
    assign rsp_err_o = 1'b0;
    logic unused_err;
    assign unused_err = rsp_err_q;
`endif

    // Pick the addressed lane out of the read word and extend it.
    always_comb begin
        logic [31:0] shifted;
        logic [7:0]  byte_val;
        logic [15:0] half_val;
        shifted   = rd_word_q >> {lane_q, 3'b000};
        byte_val  = shifted[7:0];
        half_val  = lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
        load_data = rd_word_q;
        case (size_q)
            SZ_BYTE: load_data = {{24{sign_q & byte_val[7]}}, byte_val};
            SZ_HALF: load_data = {{16{sign_q & half_val[15]}}, half_val};
            default: load_data = rd_word_q;
        endcase
    end

    // Build the word to write: full-word stores take wdata as is, sub-word
    // stores patch only the addressed lane of the word read in RD.
    always_comb begin
        wr_data = rd_word_q;
        case (size_q)
            SZ_BYTE: wr_data[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            SZ_HALF: begin
                if (lane_q[1]) wr_data[31:16] = wdata_q[15:0];
                else           wr_data[15:0]  = wdata_q[15:0];
            end
            default: wr_data = wdata_q;
        endcase
    end

    // A write only lands on a WR edge taken while out of reset.
    assign mem_we = (state == ST_WR) && rst_ni;

    // Data array: synchronous read into rd_word_q, synchronous write.
    // NOTE: the array and its read register have no reset; clearing a RAM
    // would prevent mapping it onto a memory macro, and contents after reset
    // are defined as unknown anyway.
    always_ff @(posedge clk_i) begin
        if (state == ST_RD) begin
            rd_word_q <= mem[idx_q];
        end
        if (mem_we) begin
            mem[idx_q] <= wr_data;
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_ni) begin
            state       <= ST_IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_q   <= 1'b0;
            we_q        <= 1'b0;
            size_q      <= SZ_WORD;
            sign_q      <= 1'b0;
            lane_q      <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        we_q        <= req_we_i;
                        size_q      <= req_size;
                        sign_q      <= req_sign;
                        lane_q      <= req_addr_i[1:0];
                        idx_q       <= req_addr_i[IDX_W+1:2];
                        wdata_q     <= req_wdata_i;
                        err_q       <= req_trap;
                        if (req_trap) begin
                            state <= ST_RESP;
                        end else if (req_we_i && (req_size == SZ_WORD)) begin
                            state <= ST_WR;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    state <= we_q ? ST_WR : ST_RESP;
                end
                ST_WR: begin
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    // First RESP cycle loads the response registers; they
                    // then hold until the consumer takes them.
                    if (!rsp_valid_o) begin
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= (we_q || err_q) ? 32'h0 : load_data;
                        rsp_err_q   <= err_q;
                    end else if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        rsp_rdata_o <= '0;
                        rsp_err_q   <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    req_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit
// Self-checking bench for dmem_access_unit: directed vector table, multi-cycle
// corner sequences (backpressure, misalignment, reset abort) and a randomized
// run against a byte-addressed reference memory.
// Honours DMEM_MISALIGN_TRAP_EN the same way as the design.

module tb_dmem_access_unit;

    localparam int unsigned DEPTH_WORDS = 1024;
    localparam int unsigned NBYTES      = DEPTH_WORDS * 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [2:0]  req_ext_i = 3'b0;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ref_mem [NBYTES];

    typedef struct {
        logic        we;
        logic [2:0]  ext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs [18];

    always #5 clk_i = ~clk_i;

    dmem_access_unit #(.DEPTH_WORDS(DEPTH_WORDS)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_ext_i   (req_ext_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Reference behaviour computed on a byte-addressed memory.
    function automatic void model(input logic we, input logic [2:0] ext,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rdata, output logic err,
                                  output int lat);
        int    nb;
        bit    sgn;
        int    b;
        logic [31:0] val;
        sgn = 0;
        if (we) begin
            nb = (ext == 3'd0) ? 1 : (ext == 3'd1) ? 2 : 4;
        end else begin
            case (ext)
                3'd0: begin nb = 1; sgn = 1; end
                3'd1: begin nb = 2; sgn = 1; end
                3'd2: nb = 1;
                3'd3: nb = 2;
                default: nb = 4;
            endcase
        end
        b = int'(addr % NBYTES);
        err = 1'b0;
        rdata = 32'h0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((b % nb) != 0) begin
            err = 1'b1;
            lat = 1;
            return;
        end
`endif
        b = b - (b % nb);
        if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[b + i] = wdata[8*i +: 8];
            lat = (nb == 4) ? 2 : 3;
        end else begin
            val = 32'h0;
            for (int i = 0; i < nb; i++) val = val | (32'(ref_mem[b + i]) << (8 * i));
            if (sgn && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8 * nb));
            rdata = val;
            lat = 2;
        end
    endfunction

    task automatic send_req(input logic we, input logic [2:0] ext,
                            input logic [31:0] addr, input logic [31:0] wdata);
        int guard;
        guard = 0;
        @(negedge clk_i);
        while (!req_ready_o && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        if (!req_ready_o) check("req_ready_timeout", 32'(req_ready_o), 32'h1);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_ext_i   = ext;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_we_i    = $urandom_range(0, 1);
        req_ext_i   = 3'($urandom);
        req_addr_i  = $urandom;
        req_wdata_i = $urandom;
    endtask

    // Count edges after the accept edge until rsp_valid_o is seen.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid_o && lat < 20) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
    endtask

    task automatic consume_rsp(input string name);
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b0;
        check({name, "_valid_drop"}, 32'(rsp_valid_o), 32'h0);
        check({name, "_ready_back"}, 32'(req_ready_o), 32'h1);
    endtask

    task automatic run_txn(input string name, input logic we, input logic [2:0] ext,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input int exp_lat);
        int lat;
        send_req(we, ext, addr, wdata);
        wait_rsp(lat);
        check({name, "_lat"},   32'(lat), 32'(exp_lat));
        check({name, "_rdata"}, rsp_rdata_o, exp_rdata);
        check({name, "_err"},   32'(rsp_err_o), 32'(exp_err));
        consume_rsp(name);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_req_ready"}, 32'(req_ready_o), 32'h1);
        check({name, "_rsp_valid"}, 32'(rsp_valid_o), 32'h0);
        check({name, "_rsp_rdata"}, rsp_rdata_o, 32'h0);
        check({name, "_rsp_err"},   32'(rsp_err_o), 32'h0);
    endtask

    initial begin
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;
        int          lat;
        logic        we;
        logic [2:0]  ext;
        logic [31:0] addr;
        logic [31:0] wdata;

        // Directed vectors: {we, ext, addr, wdata, expected rdata, latency}.
        vecs[0]  = '{1'b1, 3'b111, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 2};
        vecs[1]  = '{1'b0, 3'b111, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 2};
        vecs[2]  = '{1'b1, 3'b001, 32'h0000_0012, 32'h5A5A_8001, 32'h0000_0000, 3};
        vecs[3]  = '{1'b0, 3'b111, 32'h0000_0010, 32'h0,         32'h8001_BEEF, 2};
        vecs[4]  = '{1'b0, 3'b001, 32'h0000_0012, 32'h0,         32'hFFFF_8001, 2};
        vecs[5]  = '{1'b0, 3'b011, 32'h0000_0012, 32'h0,         32'h0000_8001, 2};
        vecs[6]  = '{1'b1, 3'b000, 32'h0000_0010, 32'h1234_567F, 32'h0000_0000, 3};
        vecs[7]  = '{1'b0, 3'b111, 32'h0000_0010, 32'h0,         32'h8001_BE7F, 2};
        vecs[8]  = '{1'b0, 3'b000, 32'h0000_0013, 32'h0,         32'hFFFF_FF80, 2};
        vecs[9]  = '{1'b0, 3'b010, 32'h0000_0013, 32'h0,         32'h0000_0080, 2};
        vecs[10] = '{1'b0, 3'b000, 32'h0000_0011, 32'h0,         32'hFFFF_FFBE, 2};
        vecs[11] = '{1'b0, 3'b011, 32'h0000_0010, 32'h0,         32'h0000_BE7F, 2};
        vecs[12] = '{1'b0, 3'b100, 32'h0000_0010, 32'h0,         32'h8001_BE7F, 2};
        vecs[13] = '{1'b0, 3'b111, 32'hABCD_1010, 32'h0,         32'h8001_BE7F, 2};
        vecs[14] = '{1'b1, 3'b010, 32'h0000_0020, 32'h1234_5678, 32'h0000_0000, 2};
        vecs[15] = '{1'b0, 3'b111, 32'h0000_0020, 32'h0,         32'h1234_5678, 2};
        vecs[16] = '{1'b0, 3'b001, 32'h0000_0022, 32'h0,         32'h0000_1234, 2};
        vecs[17] = '{1'b0, 3'b000, 32'h0000_0021, 32'h0,         32'h0000_0056, 2};

        // Reset state.
        rst_ni = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        foreach (vecs[i]) begin
            run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].ext, vecs[i].addr,
                    vecs[i].wdata, vecs[i].exp_rdata, 1'b0, vecs[i].exp_lat);
        end

        // Misaligned accesses; word @0x10 holds 0x8001BE7F.
`ifdef DMEM_MISALIGN_TRAP_EN
        run_txn("lw_mis",  1'b0, 3'b111, 32'h11, 32'h0, 32'h0, 1'b1, 1);
        run_txn("sw_mis",  1'b1, 3'b111, 32'h12, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
        run_txn("lh_mis",  1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 1'b1, 1);
        run_txn("lw_after_mis", 1'b0, 3'b111, 32'h10, 32'h0, 32'h8001_BE7F, 1'b0, 2);
`else
        run_txn("lw_mis",  1'b0, 3'b111, 32'h11, 32'h0, 32'h8001_BE7F, 1'b0, 2);
        run_txn("lh_mis",  1'b0, 3'b001, 32'h13, 32'h0, 32'hFFFF_8001, 1'b0, 2);
`endif

        // Backpressure: response held 5 cycles, stray request ignored.
        send_req(1'b0, 3'b111, 32'h10, 32'h0);
        wait_rsp(lat);
        check("bp_lat", 32'(lat), 32'd2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            if (c == 2) begin
                req_valid_i = 1'b1;
                req_we_i    = 1'b1;
                req_ext_i   = 3'b111;
                req_addr_i  = 32'h10;
                req_wdata_i = 32'h0;
            end else begin
                req_valid_i = 1'b0;
            end
            @(posedge clk_i);
            #1;
            check($sformatf("bp%0d_valid", c), 32'(rsp_valid_o), 32'h1);
            check($sformatf("bp%0d_rdata", c), rsp_rdata_o, 32'h8001_BE7F);
            check($sformatf("bp%0d_req_ready", c), 32'(req_ready_o), 32'h0);
        end
        @(negedge clk_i);
        req_valid_i = 1'b0;
        consume_rsp("bp");
        run_txn("bp_after", 1'b0, 3'b111, 32'h10, 32'h0, 32'h8001_BE7F, 1'b0, 2);

        // Reset during WR of a byte store aborts the write.
        send_req(1'b1, 3'b000, 32'h10, 32'hAA);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_txn("abort_after", 1'b0, 3'b111, 32'h10, 32'h0, 32'h8001_BE7F, 1'b0, 2);

        // Randomized run in a window the directed tests never touch.
        for (int w = 0; w < 16; w++) begin
            addr  = 32'h100 + 32'(4 * w);
            wdata = $urandom;
            model(1'b1, 3'b111, addr, wdata, e_rdata, e_err, e_lat);
            run_txn($sformatf("init%0d", w), 1'b1, 3'b111, addr, wdata, e_rdata, e_err, e_lat);
        end
        for (int t = 0; t < 200; t++) begin
            we    = 1'($urandom_range(0, 1));
            ext   = 3'($urandom_range(0, 7));
            addr  = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'($urandom_range(0, 63)));
            wdata = $urandom;
            model(we, ext, addr, wdata, e_rdata, e_err, e_lat);
            run_txn($sformatf("rnd%0d", t), we, ext, addr, wdata, e_rdata, e_err, e_lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
